// File: rtl/sd_img_sched.sv
// rtl/sd_img_sched.sv - multi-image SD-to-SDRAM slideshow scheduler
//
// Reads one image at a time from the SD controller user port, sector by
// sector, and streams the pixel words into the SDRAM write FIFO. Each
// 16-bit word is byte-swapped into RGB565 order. A write-address reload
// pulse precedes every image. Once an image is loaded, the block holds it
// for DWELL_CYC cycles and then fetches the next image. Images sit at a
// fixed sector stride and are visited cyclically, IMG_NUM of them.
//
// Optional feature macro: SD_IMG_HDR_SKIP_EN
//   defined   : the first HDR_WORDS words of each image (BMP header) are dropped
//   undefined : every valid word is written and HDR_WORDS is ignored
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   start_en              level, high once SD and SDRAM init are done
//   base_sec_addr         sector address of image 0
//   img_sec_stride        sector distance between consecutive images
//   sd_sec_num            sectors per image
//   rd_busy               SD controller read busy
//   sd_rd_val_en/_data    SD read data strobe and word (first byte in [15:8])
//   rd_start_en           one-cycle sector read request
//   rd_sec_addr           registered sector address of the current request
//   sdram_wr_en/_data     registered SDRAM FIFO write strobe and pixel word
//   wr_load               one-cycle SDRAM write-address reload before each image
//   img_idx               index of the image being loaded or displayed
//   frame_done            one-cycle pulse when an image's last sector completes
module sd_img_sched #(
  parameter int IMG_NUM   = 4,
  parameter int HDR_WORDS = 27,
  parameter int DWELL_CYC = 150_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_en,
  input  logic [31:0] base_sec_addr,
  input  logic [31:0] img_sec_stride,
  input  logic [15:0] sd_sec_num,
  input  logic        rd_busy,
  input  logic        sd_rd_val_en,
  input  logic [15:0] sd_rd_val_data,
  output logic        rd_start_en,
  output logic [31:0] rd_sec_addr,
  output logic        sdram_wr_en,
  output logic [15:0] sdram_wr_data,
  output logic        wr_load,
  output logic [3:0]  img_idx,
  output logic        frame_done
);

  localparam logic [3:0]  IMG_LAST   = 4'(IMG_NUM - 1);
  localparam logic [31:0] DWELL_LOAD = 32'(DWELL_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT_H, S_WAIT_L, S_NEXT, S_DWELL
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] sec_cnt_q, sec_cnt_d;
  logic [15:0] sec_num_q, sec_num_d;
  logic [31:0] img_base_q, img_base_d;
  logic [3:0]  img_idx_q, img_idx_d;
  logic [31:0] dwell_q, dwell_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic        wr_en_q, wr_en_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic [31:0] base_now;
  logic        last_sec;
  logic [15:0] swapped;

  assign last_sec = (sec_cnt_q == sec_num_q - 16'd1);
  assign swapped  = {sd_rd_val_data[7:0], sd_rd_val_data[15:8]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sec_cnt_q  <= '0;
      sec_num_q  <= '0;
      img_base_q <= '0;
      img_idx_q  <= '0;
      dwell_q    <= '0;
      rd_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      sec_cnt_q  <= sec_cnt_d;
      sec_num_q  <= sec_num_d;
      img_base_q <= img_base_d;
      img_idx_q  <= img_idx_d;
      dwell_q    <= dwell_d;
      rd_addr_q  <= rd_addr_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sec_cnt_d  = sec_cnt_q;
    sec_num_d  = sec_num_q;
    img_base_d = img_base_q;
    img_idx_d  = img_idx_q;
    dwell_d    = dwell_q;
    rd_addr_d  = rd_addr_q;
    // Image 0 always starts from the live base address, so a fresh start
    // after reset and a wrap both pick up the current base_sec_addr.
    base_now   = (img_idx_q == 4'd0) ? base_sec_addr : img_base_q;
    unique case (state_q)
      S_IDLE: if (start_en) state_d = S_LOAD;
      S_LOAD: begin
        sec_cnt_d  = '0;
        sec_num_d  = sd_sec_num;
        img_base_d = base_now;
        rd_addr_d  = base_now;
        state_d    = (sd_sec_num == 16'd0) ? S_NEXT : S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT_H;
      S_WAIT_H: if (rd_busy) state_d = S_WAIT_L;
      S_WAIT_L: begin
        if (!rd_busy) begin
          if (last_sec) begin
            state_d = S_NEXT;
          end else begin
            sec_cnt_d = sec_cnt_q + 16'd1;
            rd_addr_d = img_base_q + {16'd0, sec_cnt_q} + 32'd1;
            state_d   = S_ISSUE;
          end
        end
      end
      S_NEXT: begin
        dwell_d = DWELL_LOAD;
        state_d = S_DWELL;
      end
      S_DWELL: begin
        if (dwell_q != 32'd0) begin
          dwell_d = dwell_q - 32'd1;
        end else if (start_en) begin
          state_d = S_LOAD;
          if (img_idx_q == IMG_LAST) begin
            img_idx_d  = 4'd0;
            img_base_d = base_sec_addr;
          end else begin
            img_idx_d  = img_idx_q + 4'd1;
            img_base_d = img_base_q + img_sec_stride;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pulses are gated by rst so that a reset landing on a completion or
  // load cycle never leaks a stray strobe downstream.
  always_comb begin
    rd_start_en = 1'b0;
    wr_load     = 1'b0;
    frame_done  = 1'b0;
    if (!rst) begin
      rd_start_en = (state_q == S_ISSUE);
      wr_load     = (state_q == S_LOAD);
      // A zero-sector image reports completion from NEXT, right after LOAD.
      frame_done  = ((state_q == S_WAIT_L) && !rd_busy && last_sec) ||
                    ((state_q == S_NEXT) && (sec_num_q == 16'd0));
    end
  end

`ifdef SD_IMG_HDR_SKIP_EN
  localparam logic [15:0] HDR_LIM = 16'(HDR_WORDS);

  logic [15:0] hdr_cnt_q, hdr_cnt_d, hdr_now;

  // hdr_cnt runs across sector boundaries and stops at HDR_LIM.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    hdr_now   = (state_q == S_LOAD) ? 16'd0 : hdr_cnt_q;
    hdr_cnt_d = hdr_now;
    if (sd_rd_val_en) begin
      if (hdr_now < HDR_LIM) begin
        hdr_cnt_d = hdr_now + 16'd1;
      end else begin
        wr_en_d   = 1'b1;
        wr_data_d = swapped;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) hdr_cnt_q <= '0;
    else     hdr_cnt_q <= hdr_cnt_d;
  end
`else
  always_comb begin
    wr_en_d   = sd_rd_val_en;
    wr_data_d = sd_rd_val_en ? swapped : wr_data_q;
  end
`endif

  assign rd_sec_addr   = rd_addr_q;
  assign sdram_wr_en   = wr_en_q;
  assign sdram_wr_data = wr_data_q;
  assign img_idx       = img_idx_q;

endmodule

// File: tb/tb_sd_img_sched.sv
// tb/tb_sd_img_sched.sv - directed self-checking bench for sd_img_sched
module tb_sd_img_sched;

  localparam int IMG_NUM = 3;
  localparam int HDR     = 27;
  localparam int DW      = 10;
  localparam int WPS     = 256;
`ifdef SD_IMG_HDR_SKIP_EN
  localparam int          H_EFF  = 27;
  localparam int          WR2    = 485;
  localparam logic [15:0] FIRST0 = 16'h1BA5;
`else
  localparam int          H_EFF  = 0;
  localparam int          WR2    = 512;
  localparam logic [15:0] FIRST0 = 16'h00A5;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_en = 1'b0;
  logic [31:0] base_sec_addr = 32'h2000;
  logic [31:0] img_sec_stride = 32'h100;
  logic [15:0] sd_sec_num = 16'd2;
  logic        rd_busy = 1'b0;
  logic        sd_rd_val_en = 1'b0;
  logic [15:0] sd_rd_val_data = 16'd0;
  logic        rd_start_en;
  logic [31:0] rd_sec_addr;
  logic        sdram_wr_en;
  logic [15:0] sdram_wr_data;
  logic        wr_load;
  logic [3:0]  img_idx;
  logic        frame_done;

  sd_img_sched #(.IMG_NUM(IMG_NUM), .HDR_WORDS(HDR), .DWELL_CYC(DW)) dut (
    .clk(clk), .rst(rst), .start_en(start_en),
    .base_sec_addr(base_sec_addr), .img_sec_stride(img_sec_stride),
    .sd_sec_num(sd_sec_num), .rd_busy(rd_busy),
    .sd_rd_val_en(sd_rd_val_en), .sd_rd_val_data(sd_rd_val_data),
    .rd_start_en(rd_start_en), .rd_sec_addr(rd_sec_addr),
    .sdram_wr_en(sdram_wr_en), .sdram_wr_data(sdram_wr_data),
    .wr_load(wr_load), .img_idx(img_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cur_gidx = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int n_wl = 0, n_rs = 0, n_fd = 0;
  int img_wr_cnt = 0;
  logic [15:0] first_wr = '0;
  logic [31:0] last_req = '0;
  logic        exp_en = 1'b0;
  logic [15:0] exp_data = '0;

  int          wl_cyc_q[$];
  logic [3:0]  wl_idx_q[$];
  int          fd_cyc_q[$];
  logic [31:0] rs_addr_q[$];
  logic [3:0]  rs_idx_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Model: a valid word is written one cycle later, byte-swapped, unless it
  // lies among the first H_EFF words of the image.
  always @(posedge clk) begin
    exp_en   <= !rst && sd_rd_val_en && (cur_gidx >= H_EFF);
    exp_data <= {sd_rd_val_data[7:0], sd_rd_val_data[15:8]};
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en) begin
        if (wr_load) begin
          wl_cyc_q.push_back(cyc);
          wl_idx_q.push_back(img_idx);
          img_wr_cnt = 0;
        end
        if (rd_start_en) begin
          rs_addr_q.push_back(rd_sec_addr);
          rs_idx_q.push_back(img_idx);
          last_req = rd_sec_addr;
        end
        if (frame_done) fd_cyc_q.push_back(cyc);
        if (sdram_wr_en) begin
          if (img_wr_cnt == 0) first_wr = sdram_wr_data;
          img_wr_cnt++;
        end
        chk("wr_en", {31'd0, sdram_wr_en}, {31'd0, exp_en});
        if (exp_en) chk("wr_data", {16'd0, sdram_wr_data}, {16'd0, exp_data});
        if (rd_busy && !rst) chk("addr_hold", rd_sec_addr, last_req);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int qsize(input int which);
    case (which)
      0:       return wl_idx_q.size();
      1:       return rs_addr_q.size();
      default: return fd_cyc_q.size();
    endcase
  endfunction

  task automatic wait_ev(input int which, input int target, input int bound, input string name);
    int i = 0;
    while (qsize(which) < target && i < bound) begin
      step();
      i++;
    end
    chk(name, {31'd0, qsize(which) >= target}, 32'd1);
  endtask

  task automatic serve_sector(input logic [31:0] exp_addr, input int sec_idx, input bit last,
                              input logic [3:0] exp_idx);
    wait_ev(1, n_rs + 1, 40, "rd_start");
    if (rs_addr_q.size() > n_rs) begin
      chk("rd_sec_addr", rs_addr_q[n_rs], exp_addr);
      chk("req_idx", {28'd0, rs_idx_q[n_rs]}, {28'd0, exp_idx});
      n_rs++;
    end
    step();
    rd_busy = 1'b1;
    for (int k = 0; k < WPS; k++) begin
      step();
      sd_rd_val_en   = 1'b1;
      sd_rd_val_data = {exp_addr[7:0] ^ 8'hA5, 8'(k)};
      cur_gidx       = sec_idx * WPS + k;
    end
    step();
    sd_rd_val_en = 1'b0;
    rd_busy      = 1'b0;
    cur_gidx     = 0;
    if (last) begin
      wait_ev(2, n_fd + 1, 5, "frame_done");
      if (fd_cyc_q.size() > n_fd) n_fd++;
    end else begin
      chk("no_early_fd", fd_cyc_q.size(), n_fd);
    end
  endtask

  // act: 1 = drop start_en, 2 = set sd_sec_num to 0, applied after sector act_at
  task automatic run_image(input logic [31:0] a0, input logic [3:0] idx, input int nsec,
                           input int gap_exp, input int wl_bound, input int act_at, input int act);
    wait_ev(0, n_wl + 1, wl_bound, "wr_load");
    if (wl_idx_q.size() > n_wl) begin
      chk("load_idx", {28'd0, wl_idx_q[n_wl]}, {28'd0, idx});
      if (gap_exp > 0 && n_fd > 0)
        chk("dwell_gap", wl_cyc_q[n_wl] - fd_cyc_q[n_fd-1], gap_exp);
      n_wl++;
    end
    for (int s = 0; s < nsec; s++) begin
      serve_sector(a0 + 32'(s), s, s == nsec - 1, idx);
      if (s == act_at && act == 1) start_en = 1'b0;
      if (s == act_at && act == 2) sd_sec_num = 16'd0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    mon_en = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("rst_rd_start", {31'd0, rd_start_en}, 32'd0);
    chk("rst_addr", rd_sec_addr, 32'd0);
    chk("rst_wr_en", {31'd0, sdram_wr_en}, 32'd0);
    chk("rst_wr_load", {31'd0, wr_load}, 32'd0);
    chk("rst_idx", {28'd0, img_idx}, 32'd0);
    chk("rst_fd", {31'd0, frame_done}, 32'd0);

    // Single image at 0x2000, then base changes mid-rotation (seen at wrap).
    start_en = 1'b1;
    run_image(32'h2000, 4'd0, 2, 0, 3, -1, 0);
    chk("img0_wr_count", img_wr_cnt, WR2);
    chk("img0_first_wr", {16'd0, first_wr}, {16'd0, FIRST0});
    base_sec_addr = 32'h1000;
    run_image(32'h2100, 4'd1, 2, DW + 2, DW + 40, -1, 0);
    run_image(32'h2200, 4'd2, 2, DW + 2, DW + 40, -1, 0);
    run_image(32'h1000, 4'd0, 2, DW + 2, DW + 40, -1, 0);
    chk("img_wr_count", img_wr_cnt, WR2);

    // start_en dropped after the first sector: image completes, then IDLE.
    run_image(32'h1100, 4'd1, 2, DW + 2, DW + 40, 0, 1);
    repeat (40) step();
    chk("idle_no_load", wl_idx_q.size(), n_wl);
    chk("idle_no_req", rs_addr_q.size(), n_rs);
    chk("idle_idx", {28'd0, img_idx}, 32'd1);
    start_en = 1'b1;
    run_image(32'h1100, 4'd1, 2, 0, 3, 0, 2);

    // Zero-sector image: wr_load, frame_done next cycle, no reads.
    wait_ev(0, n_wl + 1, DW + 40, "zero_wr_load");
    if (wl_idx_q.size() > n_wl) begin
      chk("zero_idx", {28'd0, wl_idx_q[n_wl]}, 32'd2);
      chk("zero_dwell_gap", wl_cyc_q[n_wl] - fd_cyc_q[n_fd-1], DW + 2);
      n_wl++;
    end
    wait_ev(2, n_fd + 1, 4, "zero_fd");
    if (fd_cyc_q.size() > n_fd) begin
      chk("zero_fd_lat", fd_cyc_q[n_fd] - wl_cyc_q[n_wl-1], 1);
      n_fd++;
    end
    sd_sec_num = 16'd1;
    wait_ev(0, n_wl + 1, DW + 40, "after_zero_load");
    chk("zero_no_req", rs_addr_q.size(), n_rs);
    if (wl_idx_q.size() > n_wl) begin
      chk("wrap_idx", {28'd0, wl_idx_q[n_wl]}, 32'd0);
      chk("zero_to_load", wl_cyc_q[n_wl] - fd_cyc_q[n_fd-1], DW + 1);
      n_wl++;
    end

    // Reset in WAIT_L on the last sector while data is still valid.
    wait_ev(1, n_rs + 1, 10, "rst_case_req");
    if (rs_addr_q.size() > n_rs) begin
      chk("rst_case_addr", rs_addr_q[n_rs], 32'h1000);
      n_rs++;
    end
    step();
    rd_busy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      sd_rd_val_en   = 1'b1;
      sd_rd_val_data = {8'hA5, 8'(k)};
      cur_gidx       = k;
    end
    step();
    rst     = 1'b1;
    rd_busy = 1'b0;
    sd_rd_val_data = 16'h1234;
    step();
    chk("mid_rst_rd_start", {31'd0, rd_start_en}, 32'd0);
    chk("mid_rst_addr", rd_sec_addr, 32'd0);
    chk("mid_rst_wr_en", {31'd0, sdram_wr_en}, 32'd0);
    chk("mid_rst_wr_data", {16'd0, sdram_wr_data}, 32'd0);
    chk("mid_rst_wr_load", {31'd0, wr_load}, 32'd0);
    chk("mid_rst_fd", {31'd0, frame_done}, 32'd0);
    step();
    rst = 1'b0;
    start_en = 1'b0;
    sd_rd_val_en = 1'b0;
    cur_gidx = 0;
    repeat (10) step();
    chk("post_rst_no_fd", fd_cyc_q.size(), n_fd);
    chk("post_rst_no_load", wl_idx_q.size(), n_wl);
    chk("post_rst_idx", {28'd0, img_idx}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
